// File: rtl/tri_bus_pkg.sv
// Shared types and constants for the tristate bus serializer.
package tri_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } state_t;

  // Line level while the driver is released (and the stop-bit level).
  localparam logic BUS_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL    = 1'b0;

  // Shared bit/gap counter width: covers WIDTH-1 <= 31 and GAP-1 <= 14.
  localparam int CNT_W = 6;

  // Number of cycles BUS_EN stays high for one complete frame.
  function automatic int frame_len(input int width, input int parity_en);
    return 2 + width + parity_en;
  endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// WIDTH-bit right-shifting transmit register with parity latched at load.
module tx_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             parity
);

  logic [WIDTH-1:0] sr_q;
  logic             par_q;

  // Load wins over shift; parity is taken from the whole word at load
  // time because the register contents are consumed as bits go out.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sr_q  <= '0;
      par_q <= 1'b0;
    end else if (load) begin
      sr_q  <= din;
      par_q <= ^din;
    end else if (shift) begin
      sr_q  <= sr_q >> 1;
    end
  end

  assign sout   = sr_q[0];
  assign parity = par_q;

endmodule

// File: rtl/tri_bus_serializer.sv
// Framed parallel-to-serial transmitter for one line of a shared tristate
// bus. BUS_DATA/BUS_EN feed the A/EN pins of the bus driver directly.
module tri_bus_serializer
  import tri_bus_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1,
  parameter int GAP       = 2
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             BUS_REQ,
  input  logic             BUS_GNT,
  output logic             BUS_EN,
  output logic             BUS_DATA,
  output logic             BUSY,
  output logic             DONE,
  output logic             ABORT
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sr_load, sr_shift, sr_sout, sr_par;
  logic             rdy_d, req_d, en_d, dat_d, busy_d, done_d, abort_d;

  tx_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .load   (sr_load),
    .shift  (sr_shift),
    .din    (DIN),
    .sout   (sr_sout),
    .parity (sr_par)
  );

  // Next state plus next output values; outputs are derived from the next
  // state so every port comes straight off a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (DIN_VALID && DIN_READY) begin
          sr_load = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (BUS_GNT) state_d = ST_START;
      end
      ST_START: begin
        if (!BUS_GNT) abort_d = 1'b1;
        else begin
          state_d  = ST_DATA;
          cnt_d    = '0;
          sr_shift = 1'b1;
        end
      end
      ST_DATA: begin
        if (!BUS_GNT) abort_d = 1'b1;
        else if (cnt_q == LAST_BIT) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        else begin
          cnt_d    = cnt_q + CNT_W'(1);
          sr_shift = 1'b1;
        end
      end
      ST_PARITY: begin
        if (!BUS_GNT) abort_d = 1'b1;
        else state_d = ST_STOP;
      end
      ST_STOP: begin
        if (!BUS_GNT) abort_d = 1'b1;
        else done_d = 1'b1;
      end
      ST_GAP: begin
        if (cnt_q == LAST_GAP) state_d = ST_IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Completed and aborted frames both release the bus into the guard gap.
    if (done_d || abort_d) begin
      state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
      cnt_d   = '0;
    end

    rdy_d  = (state_d == ST_IDLE);
    busy_d = !rdy_d;
    en_d   = (state_d == ST_START) || (state_d == ST_DATA) ||
             (state_d == ST_PARITY) || (state_d == ST_STOP);
    req_d  = en_d || (state_d == ST_REQ);
    case (state_d)
      ST_START:  dat_d = START_LEVEL;
      ST_DATA:   dat_d = sr_sout;
      ST_PARITY: dat_d = sr_par;
      default:   dat_d = BUS_IDLE_LEVEL;
    endcase
  end

  // State, counter and registered outputs; reset releases the bus at once.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      DIN_READY <= 1'b1;
      BUS_REQ   <= 1'b0;
      BUS_EN    <= 1'b0;
      BUS_DATA  <= BUS_IDLE_LEVEL;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ABORT     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      DIN_READY <= rdy_d;
      BUS_REQ   <= req_d;
      BUS_EN    <= en_d;
      BUS_DATA  <= dat_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      ABORT     <= abort_d;
    end
  end

endmodule

// File: tb/tb_tri_bus_serializer.sv
// Directed bench: dut_a = (8, parity, gap 2), dut_b = (8, no parity, gap 0).
module tb_tri_bus_serializer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] din_a, din_b;
  logic vld_a, vld_b, gnt_a, gnt_b;
  logic rdy_a, req_a, en_a, dat_a, busy_a, done_a, abort_a;
  logic rdy_b, req_b, en_b, dat_b, busy_b, done_b, abort_b;

  int total = 0;
  int bad   = 0;

  tri_bus_serializer #(.WIDTH(8), .PARITY_EN(1), .GAP(2)) dut_a (
    .CLK(clk), .RSTN(rstn), .DIN(din_a), .DIN_VALID(vld_a), .DIN_READY(rdy_a),
    .BUS_REQ(req_a), .BUS_GNT(gnt_a), .BUS_EN(en_a), .BUS_DATA(dat_a),
    .BUSY(busy_a), .DONE(done_a), .ABORT(abort_a)
  );

  tri_bus_serializer #(.WIDTH(8), .PARITY_EN(0), .GAP(0)) dut_b (
    .CLK(clk), .RSTN(rstn), .DIN(din_b), .DIN_VALID(vld_b), .DIN_READY(rdy_b),
    .BUS_REQ(req_b), .BUS_GNT(gnt_b), .BUS_EN(en_b), .BUS_DATA(dat_b),
    .BUSY(busy_b), .DONE(done_b), .ABORT(abort_b)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // {rdy,req,en,dat,busy,done,abort} must read 1001000 under reset.
  task automatic test_reset;
    din_a = '0; din_b = '0; vld_a = 1'b0; vld_b = 1'b0;
    gnt_a = 1'b1; gnt_b = 1'b1;
    rstn = 1'b0;
    #12;
    total++;
    if ({rdy_a, req_a, en_a, dat_a, busy_a, done_a, abort_a} !== 7'b1001000) begin
      bad++; $display("FAIL reset_a: got %b want 1001000",
                      {rdy_a, req_a, en_a, dat_a, busy_a, done_a, abort_a});
    end
    total++;
    if ({rdy_b, req_b, en_b, dat_b, busy_b, done_b, abort_b} !== 7'b1001000) begin
      bad++; $display("FAIL reset_b: got %b want 1001000",
                      {rdy_b, req_b, en_b, dat_b, busy_b, done_b, abort_b});
    end
    @(negedge clk);
    rstn = 1'b1;
    step;
    total++;
    if ({rdy_a, en_a, dat_a, busy_a} !== 4'b1010) begin
      bad++; $display("FAIL idle_after_reset: got %b want 1010", {rdy_a, en_a, dat_a, busy_a});
    end
  endtask

  // Full frame on dut_a with grant already high; exp[i] is the i-th bit after
  // the start bit (8 data LSB-first, parity, stop).
  task automatic test_frame_a(input logic [7:0] w, input logic [9:0] exp);
    int en_cnt;
    en_cnt = 0;
    gnt_a = 1'b1;
    din_a = w; vld_a = 1'b1;
    step;
    vld_a = 1'b0; din_a = ~w;
    total++;
    if ({req_a, rdy_a, en_a, dat_a, busy_a} !== 5'b10011) begin
      bad++; $display("FAIL frame_req %h: got %b want 10011", w, {req_a, rdy_a, en_a, dat_a, busy_a});
    end
    step;
    total++;
    if ({en_a, dat_a} !== 2'b10) begin
      bad++; $display("FAIL frame_start %h: got %b want 10", w, {en_a, dat_a});
    end
    if (en_a) en_cnt++;
    for (int i = 0; i < 10; i++) begin
      step;
      if (en_a) en_cnt++;
      total++;
      if ({en_a, dat_a, done_a} !== {1'b1, exp[i], 1'b0}) begin
        bad++; $display("FAIL frame_bit%0d %h: got en/dat/done %b want %b", i, w,
                        {en_a, dat_a, done_a}, {1'b1, exp[i], 1'b0});
      end
    end
    step;
    if (en_a) en_cnt++;
    total++;
    if ({en_a, dat_a, done_a, req_a, rdy_a} !== 5'b01100) begin
      bad++; $display("FAIL frame_done %h: got %b want 01100", w, {en_a, dat_a, done_a, req_a, rdy_a});
    end
    total++;
    if (en_cnt !== 11) begin
      bad++; $display("FAIL frame_en_len %h: got %0d want 11", w, en_cnt);
    end
    step;
    total++;
    if ({done_a, rdy_a, dat_a} !== 3'b001) begin
      bad++; $display("FAIL frame_gap2 %h: got %b want 001", w, {done_a, rdy_a, dat_a});
    end
    step;
    total++;
    if ({rdy_a, busy_a} !== 2'b10) begin
      bad++; $display("FAIL frame_idle %h: got %b want 10", w, {rdy_a, busy_a});
    end
  endtask

  // 0x07 without parity on dut_b: 10 enable cycles, straight back to idle.
  task automatic test_no_parity;
    logic [8:0] exp;
    int en_cnt;
    exp = 9'b100000111;
    en_cnt = 0;
    gnt_b = 1'b1;
    din_b = 8'h07; vld_b = 1'b1;
    step;
    vld_b = 1'b0;
    total++;
    if ({req_b, rdy_b, en_b} !== 3'b100) begin
      bad++; $display("FAIL nopar_req: got %b want 100", {req_b, rdy_b, en_b});
    end
    step;
    if (en_b) en_cnt++;
    total++;
    if ({en_b, dat_b} !== 2'b10) begin
      bad++; $display("FAIL nopar_start: got %b want 10", {en_b, dat_b});
    end
    for (int i = 0; i < 9; i++) begin
      step;
      if (en_b) en_cnt++;
      total++;
      if ({en_b, dat_b} !== {1'b1, exp[i]}) begin
        bad++; $display("FAIL nopar_bit%0d: got %b want %b", i, {en_b, dat_b}, {1'b1, exp[i]});
      end
    end
    step;
    if (en_b) en_cnt++;
    total++;
    if ({en_b, dat_b, done_b, rdy_b, req_b} !== 5'b01110) begin
      bad++; $display("FAIL nopar_done: got %b want 01110", {en_b, dat_b, done_b, rdy_b, req_b});
    end
    total++;
    if (en_cnt !== 10) begin
      bad++; $display("FAIL nopar_en_len: got %0d want 10", en_cnt);
    end
  endtask

  // Grant withheld for 5 cycles: request held, bus not driven.
  task automatic test_grant_wait;
    int n;
    logic done_seen;
    gnt_a = 1'b0;
    din_a = 8'h3C; vld_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step;
      vld_a = 1'b0;
      total++;
      if ({req_a, en_a, dat_a} !== 3'b101) begin
        bad++; $display("FAIL gwait_req%0d: got %b want 101", k, {req_a, en_a, dat_a});
      end
    end
    gnt_a = 1'b1;
    step;
    total++;
    if ({en_a, dat_a} !== 2'b10) begin
      bad++; $display("FAIL gwait_start: got %b want 10", {en_a, dat_a});
    end
    n = 0; done_seen = 1'b0;
    while (!rdy_a && n < 30) begin
      step;
      if (done_a) done_seen = 1'b1;
      n++;
    end
    total++;
    if (!(rdy_a && done_seen)) begin
      bad++; $display("FAIL gwait_finish: rdy=%b done_seen=%b want 1 1", rdy_a, done_seen);
    end
  endtask

  // Grant drops during data bit 3 of 0xFF.
  task automatic test_abort;
    gnt_a = 1'b1;
    din_a = 8'hFF; vld_a = 1'b1;
    step;
    vld_a = 1'b0;
    for (int k = 0; k < 5; k++) step;
    total++;
    if ({en_a, dat_a} !== 2'b11) begin
      bad++; $display("FAIL abort_bit3: got %b want 11", {en_a, dat_a});
    end
    gnt_a = 1'b0;
    step;
    gnt_a = 1'b1;
    total++;
    if ({en_a, dat_a, abort_a, done_a, req_a, busy_a} !== 6'b011001) begin
      bad++; $display("FAIL abort_pulse: got %b want 011001",
                      {en_a, dat_a, abort_a, done_a, req_a, busy_a});
    end
    step;
    total++;
    if ({abort_a, done_a, rdy_a, en_a} !== 4'b0000) begin
      bad++; $display("FAIL abort_gap: got %b want 0000", {abort_a, done_a, rdy_a, en_a});
    end
    step;
    total++;
    if ({rdy_a, busy_a} !== 2'b10) begin
      bad++; $display("FAIL abort_idle: got %b want 10", {rdy_a, busy_a});
    end
  endtask

  // DIN_VALID held high with DIN changing every cycle on dut_b (GAP=0).
  // A small line decoder rebuilds each frame and compares with the words
  // seen while DIN_READY was high.
  task automatic test_back_to_back;
    logic [7:0] q[$];
    logic [7:0] word, expw;
    int pos, frames, accepted;
    pos = -1; frames = 0; accepted = 0; word = '0;
    gnt_b = 1'b1;
    for (int c = 0; c < 40; c++) begin
      din_b = 8'(c * 37 + 11);
      vld_b = 1'b1;
      if (rdy_b) begin
        q.push_back(din_b);
        accepted++;
      end
      if (en_b) begin
        if (pos < 0) begin
          total++;
          if (dat_b !== 1'b0) begin
            bad++; $display("FAIL b2b_start c%0d: got %b want 0", c, dat_b);
          end
          pos = 0;
        end else if (pos < 8) begin
          word[pos] = dat_b;
          pos++;
        end else begin
          total++;
          if (dat_b !== 1'b1) begin
            bad++; $display("FAIL b2b_stop c%0d: got %b want 1", c, dat_b);
          end
          expw = (q.size() > 0) ? q.pop_front() : 8'h00;
          total++;
          if (word !== expw) begin
            bad++; $display("FAIL b2b_word%0d: got %h want %h", frames, word, expw);
          end
          frames++;
          pos = -1;
        end
      end else begin
        total++;
        if (dat_b !== 1'b1 || pos >= 0) begin
          bad++; $display("FAIL b2b_idle c%0d: dat=%b pos=%0d want dat 1 pos -1", c, dat_b, pos);
        end
        pos = -1;
      end
      step;
    end
    vld_b = 1'b0;
    total++;
    if (frames !== 3 || accepted !== 4) begin
      bad++; $display("FAIL b2b_count: frames=%0d accepted=%0d want 3 4", frames, accepted);
    end
  endtask

  // Reset pulled mid-data between clock edges; outputs must drop before the
  // next edge and a later frame must go out cleanly.
  task automatic test_async_reset;
    gnt_a = 1'b1;
    din_a = 8'h5A; vld_a = 1'b1;
    step;
    vld_a = 1'b0;
    for (int k = 0; k < 4; k++) step;
    total++;
    if (en_a !== 1'b1) begin
      bad++; $display("FAIL arst_pre: en got %b want 1", en_a);
    end
    #3;
    rstn = 1'b0;
    #1;
    total++;
    if ({rdy_a, req_a, en_a, dat_a, busy_a, done_a, abort_a} !== 7'b1001000) begin
      bad++; $display("FAIL arst_async: got %b want 1001000",
                      {rdy_a, req_a, en_a, dat_a, busy_a, done_a, abort_a});
    end
    step;
    total++;
    if ({en_a, busy_a} !== 2'b00) begin
      bad++; $display("FAIL arst_hold: got %b want 00", {en_a, busy_a});
    end
    #4;
    rstn = 1'b1;
    step;
    test_frame_a(8'h81, 10'b1010000001);
  endtask

  initial begin
    test_reset;
    test_frame_a(8'hA5, 10'b1010100101);
    test_frame_a(8'h07, 10'b1100000111);
    test_no_parity;
    test_grant_wait;
    test_abort;
    test_back_to_back;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
